i_decode: RTL and testbench
===========================

I_DECODE -- requirements
Module: i_decode

Interface
REQ-001 Parameters: WORD, 64, datapath width; INSTR_LEN, 32, instruction width.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  sole clock; register-file writes on rising edge.
REQ-004 reset  in  1  asynchronous active-high reset of register file.
REQ-005 instruction  in  INSTR_LEN  LEGv8 instruction, combinational decode.
REQ-006 write_data  in  WORD  value written to Rd.
REQ-007 opcode  out  11  instruction[31:21].
REQ-008 sign_extended_output  out  WORD  sign-extended immediate.
REQ-009 reg2_loc, uncondbranch, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write  out  1 each  control signals.
REQ-010 alu_op  out  2  ALU operation class.
REQ-011 read_data1, read_data2  out  WORD  register-file read ports.

Function
REQ-012 Fields: Rd/Rt=instr[4:0], Rn=instr[9:5], Rm=instr[20:16]; read_data1=X[Rn]; read_data2=X[reg2_loc ? Rt : Rm].
REQ-013 Reads SHALL be combinational; X31 SHALL always read 0 and ignore writes.
REQ-014 Write: on rising clk with reg_write=1 and Rd!=31, X[Rd] <= write_data, using the instruction present before the edge; reads after the edge return the new value.
REQ-015 R-type (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000): reg2_loc=0, alu_src=0, mem_to_reg=0, reg_write=1, mem_read=0, mem_write=0, branch=0, uncondbranch=0, alu_op=10.
REQ-016 LDUR 11111000010: reg2_loc=0, alu_src=1, mem_to_reg=1, reg_write=1, mem_read=1, mem_write=0, branch=0, uncondbranch=0, alu_op=00.
REQ-017 STUR 11111000000: reg2_loc=1, alu_src=1, mem_to_reg=0, reg_write=0, mem_read=0, mem_write=1, branch=0, uncondbranch=0, alu_op=00.
REQ-018 CBZ (opcode[10:3]=10110100): reg2_loc=1, alu_src=0, mem_to_reg=0, reg_write=0, mem_read=0, mem_write=0, branch=1, uncondbranch=0, alu_op=01.
REQ-019 B (opcode[10:5]=000101): uncondbranch=1, all other controls 0, alu_op=00.
REQ-020 Any other opcode: all control outputs 0, alu_op=00.
REQ-021 Immediate: D-type sext(instr[20:12]); CBZ sext(instr[23:5]); B sext(instr[25:0]); R-type/other 0; no shift applied.
REQ-022 All decode outputs SHALL be purely combinational from instruction and register contents (zero-cycle latency).

Reset
REQ-023 reset=1 SHALL asynchronously load every register from package constant REG_INIT: X19=10, X20=30, X22=16, all others 0.
REQ-024 While reset=1, writes SHALL be blocked; decode outputs remain combinational.
REQ-025 Reset deasserted mid-cycle: first write occurs on the next rising clk edge.

Structure
REQ-026 Shared package SHALL hold WORD, INSTR_LEN, opcode constants, alu_op encodings and REG_INIT.
REQ-027 The 32x WORD register file SHALL be a sub-module named reg_file (async reset, 2 combinational read ports, 1 synchronous write port); control decode and sign extension live in i_decode.

Verification
REQ-028 After reset, LDUR X9,[X22,#64] (F84402C9) -> opcode 11111000010, imm 0x40, mem_read=1, mem_to_reg=1, alu_src=1, reg_write=1, alu_op=00, read_data1=16.
REQ-029 write_data=20 then clk edge; ADD X10,X19,X9 (8B09026A) -> alu_op=10, reg_write=1, read_data1=10, read_data2=20.
REQ-030 write_data=30 then clk edge; SUB X11,X20,X10 (CB0A028B) -> opcode 11001011000, read_data1=30, read_data2=30.
REQ-031 CBZ X11,-5 -> branch=1, reg2_loc=1, alu_op=01, imm 0xFFFFFFFFFFFFFFFB; B 64 -> uncondbranch=1, imm 0x40.
REQ-032 STUR X11,[X22,#96] -> mem_write=1, reg_write=0, imm 0x60, read_data2=X11; write attempted to X31 -> read stays 0.
REQ-033 Assert reset mid-cycle after writes -> X9, X10 immediately return REG_INIT values (0).

Source files
------------

// File: rtl/i_decode_pkg.sv
// Shared definitions for the LEGv8 decode stage: widths, opcodes, control
// encodings and the register-file reset image.
package i_decode_pkg;

   localparam int WORD      = 64;
   localparam int INSTR_LEN = 32;
   localparam int NUM_REGS  = 32;

   localparam logic [4:0] ZERO_REG = 5'd31;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;
   localparam logic [5:0]  OP_B_PFX   = 6'b000101;

   typedef enum logic [1:0] {
      ALU_ADD    = 2'b00,
      ALU_PASS_B = 2'b01,
      ALU_FUNCT  = 2'b10
   } alu_op_e;

   typedef enum logic [2:0] {
      CLS_R,
      CLS_LOAD,
      CLS_STORE,
      CLS_CBZ,
      CLS_B,
      CLS_NONE
   } instr_class_e;

   typedef struct packed {
      logic    reg2_loc;
      logic    alu_src;
      logic    mem_to_reg;
      logic    reg_write;
      logic    mem_read;
      logic    mem_write;
      logic    branch;
      logic    uncondbranch;
      alu_op_e alu_op;
   } ctrl_t;

   typedef logic [WORD-1:0] reg_array_t [NUM_REGS];

   localparam reg_array_t REG_INIT = '{
      19: 64'd10,
      20: 64'd30,
      22: 64'd16,
      default: '0
   };

   function automatic instr_class_e classify(input logic [10:0] op);
      instr_class_e cls;
      cls = CLS_NONE;
      if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) begin
         cls = CLS_R;
      end else if (op == OP_LDUR) begin
         cls = CLS_LOAD;
      end else if (op == OP_STUR) begin
         cls = CLS_STORE;
      end else if (op[10:3] == OP_CBZ_PFX) begin
         cls = CLS_CBZ;
      end else if (op[10:5] == OP_B_PFX) begin
         cls = CLS_B;
      end
      return cls;
   endfunction

endpackage

// File: rtl/i_decode_reg_file.sv
// 32-entry register file: two combinational read ports, one synchronous write
// port, X31 hard-wired to zero.
module reg_file #(
   parameter int WORD = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [4:0]      rd_addr_a,
   input  logic [4:0]      rd_addr_b,
   input  logic            wr_en,
   input  logic [4:0]      wr_addr,
   input  logic [WORD-1:0] wr_data,
   output logic [WORD-1:0] rd_data_a,
   output logic [WORD-1:0] rd_data_b
);
   import i_decode_pkg::*;

   logic [WORD-1:0] regs_q [NUM_REGS];
   logic [WORD-1:0] regs_d [NUM_REGS];

   always_comb begin
      regs_d = regs_q;
      if (wr_en && wr_addr != ZERO_REG) begin
         regs_d[wr_addr] = wr_data;
      end
   end

   // NOTE: this array is reset to a defined image on purpose; a plain storage
   // array without reset would map to denser RAM, but the boot values matter here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regs_q <= REG_INIT;
      end else begin
         regs_q <= regs_d;
      end
   end

   assign rd_data_a = (rd_addr_a == ZERO_REG) ? '0 : regs_q[rd_addr_a];
   assign rd_data_b = (rd_addr_b == ZERO_REG) ? '0 : regs_q[rd_addr_b];

endmodule

// File: rtl/i_decode.sv
// LEGv8 instruction decode: control generation, immediate sign extension and
// register-file access, all combinational apart from the register writes.
module i_decode #(
   parameter int WORD      = i_decode_pkg::WORD,
   parameter int INSTR_LEN = i_decode_pkg::INSTR_LEN
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [INSTR_LEN-1:0] instruction,
   input  logic [WORD-1:0]      write_data,
   output logic [10:0]          opcode,
   output logic [WORD-1:0]      sign_extended_output,
   output logic                 reg2_loc,
   output logic                 uncondbranch,
   output logic                 branch,
   output logic                 mem_read,
   output logic                 mem_to_reg,
   output logic                 mem_write,
   output logic                 alu_src,
   output logic                 reg_write,
   output logic [1:0]           alu_op,
   output logic [WORD-1:0]      read_data1,
   output logic [WORD-1:0]      read_data2
);
   import i_decode_pkg::*;

   instr_class_e    cls;
   ctrl_t           ctrl;
   logic [WORD-1:0] imm;
   logic [4:0]      rd_rt;
   logic [4:0]      rn;
   logic [4:0]      rm;
   logic [4:0]      reg2_addr;

   assign opcode = instruction[31:21];
   assign rd_rt  = instruction[4:0];
   assign rn     = instruction[9:5];
   assign rm     = instruction[20:16];

   always_comb begin
      cls  = classify(opcode);
      ctrl = '0;
      imm  = '0;
      case (cls)
         CLS_R: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALU_FUNCT;
         end
         CLS_LOAD: begin
            ctrl.alu_src    = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.mem_read   = 1'b1;
            imm = {{(WORD-9){instruction[20]}}, instruction[20:12]};
         end
         CLS_STORE: begin
            ctrl.reg2_loc  = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.mem_write = 1'b1;
            imm = {{(WORD-9){instruction[20]}}, instruction[20:12]};
         end
         CLS_CBZ: begin
            ctrl.reg2_loc = 1'b1;
            ctrl.branch   = 1'b1;
            ctrl.alu_op   = ALU_PASS_B;
            imm = {{(WORD-19){instruction[23]}}, instruction[23:5]};
         end
         CLS_B: begin
            ctrl.uncondbranch = 1'b1;
            imm = {{(WORD-26){instruction[25]}}, instruction[25:0]};
         end
         default: begin
            ctrl = '0;
         end
      endcase
   end

   assign reg2_loc             = ctrl.reg2_loc;
   assign alu_src              = ctrl.alu_src;
   assign mem_to_reg           = ctrl.mem_to_reg;
   assign reg_write            = ctrl.reg_write;
   assign mem_read             = ctrl.mem_read;
   assign mem_write            = ctrl.mem_write;
   assign branch               = ctrl.branch;
   assign uncondbranch         = ctrl.uncondbranch;
   assign alu_op               = ctrl.alu_op;
   assign sign_extended_output = imm;

   // Store and CBZ read their data operand from the Rt field, not Rm.
   assign reg2_addr = ctrl.reg2_loc ? rd_rt : rm;

   reg_file #(
      .WORD(WORD)
   ) u_reg_file (
      .clk       (clk),
      .reset     (reset),
      .rd_addr_a (rn),
      .rd_addr_b (reg2_addr),
      .wr_en     (ctrl.reg_write),
      .wr_addr   (rd_rt),
      .wr_data   (write_data),
      .rd_data_a (read_data1),
      .rd_data_b (read_data2)
   );

endmodule

// File: tb/tb_i_decode.sv
// Bench for i_decode: directed instruction sequence followed by random
// instructions, all compared against a behavioural decode/register model.
module tb_i_decode;

   logic        clk;
   logic        reset;
   logic [31:0] instruction;
   logic [63:0] write_data;
   logic [10:0] opcode;
   logic [63:0] sign_extended_output;
   logic        reg2_loc, uncondbranch, branch, mem_read, mem_to_reg;
   logic        mem_write, alu_src, reg_write;
   logic [1:0]  alu_op;
   logic [63:0] read_data1, read_data2;

   int n_checks = 0;
   int n_pass   = 0;

   logic [63:0] model_regs [32];

   i_decode dut (
      .clk                  (clk),
      .reset                (reset),
      .instruction          (instruction),
      .write_data           (write_data),
      .opcode               (opcode),
      .sign_extended_output (sign_extended_output),
      .reg2_loc             (reg2_loc),
      .uncondbranch         (uncondbranch),
      .branch               (branch),
      .mem_read             (mem_read),
      .mem_to_reg           (mem_to_reg),
      .mem_write            (mem_write),
      .alu_src              (alu_src),
      .reg_write            (reg_write),
      .alu_op               (alu_op),
      .read_data1           (read_data1),
      .read_data2           (read_data2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Control word order: reg2_loc alu_src mem_to_reg reg_write mem_read
   // mem_write branch uncondbranch alu_op[1:0].
   function automatic logic [9:0] exp_ctrl(input logic [31:0] ins);
      logic [10:0] op;
      op = ins[31:21];
      if (op == 11'h458 || op == 11'h658 || op == 11'h450 || op == 11'h550)
         return 10'b0001000010;
      if (op == 11'h7C2) return 10'b0111100000;
      if (op == 11'h7C0) return 10'b1100010000;
      if (op[10:3] == 8'hB4) return 10'b1000001001;
      if (op[10:5] == 6'b000101) return 10'b0000000100;
      return 10'b0;
   endfunction

   function automatic logic [63:0] exp_imm(input logic [31:0] ins);
      logic [10:0] op;
      longint v;
      op = ins[31:21];
      v  = 0;
      if (op == 11'h7C2 || op == 11'h7C0) begin
         v = longint'(ins[20:12]);
         if (v >= 256) v = v - 512;
      end else if (op[10:3] == 8'hB4) begin
         v = longint'(ins[23:5]);
         if (v >= (1 << 18)) v = v - (1 << 19);
      end else if (op[10:5] == 6'b000101) begin
         v = longint'(ins[25:0]);
         if (v >= (1 << 25)) v = v - (1 << 26);
      end
      return 64'(v);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) model_regs[i] = 64'd0;
      model_regs[19] = 64'd10;
      model_regs[20] = 64'd30;
      model_regs[22] = 64'd16;
   endtask

   task automatic check_all(input string tag);
      logic [9:0]  ec;
      logic [4:0]  r2;
      ec = exp_ctrl(instruction);
      r2 = ec[9] ? instruction[4:0] : instruction[20:16];
      check({tag, ".opcode"}, 64'(opcode), 64'(instruction[31:21]));
      check({tag, ".ctrl"}, 64'({reg2_loc, alu_src, mem_to_reg, reg_write, mem_read,
                                 mem_write, branch, uncondbranch, alu_op}), 64'(ec));
      check({tag, ".imm"}, sign_extended_output, exp_imm(instruction));
      check({tag, ".rd1"}, read_data1, model_regs[instruction[9:5]]);
      check({tag, ".rd2"}, read_data2, model_regs[r2]);
   endtask

   task automatic drive(input logic [31:0] ins, input logic [63:0] wd, input string tag);
      @(negedge clk);
      instruction = ins;
      write_data  = wd;
      #1;
      check_all(tag);
   endtask

   task automatic tick();
      logic [9:0] ec;
      @(posedge clk);
      ec = exp_ctrl(instruction);
      if (!reset && ec[6] && instruction[4:0] != 5'd31)
         model_regs[instruction[4:0]] = write_data;
   endtask

   initial begin
      logic [31:0] r;
      logic [10:0] op;
      logic [31:0] ins;

      reset       = 1'b1;
      instruction = 32'h8B140260;
      write_data  = 64'd0;
      model_reset();
      #1;
      check_all("reset_init");
      check("reset_x19", read_data1, 64'd10);
      check("reset_x20", read_data2, 64'd30);
      tick();
      check("reset_blocks_write", read_data1, 64'd10);

      // Release reset mid-cycle; the next rising edge performs the first write.
      @(negedge clk);
      reset = 1'b0;

      drive(32'hF84402C9, 64'd20, "ldur");
      check("ldur.imm_const", sign_extended_output, 64'h40);
      check("ldur.rd1_const", read_data1, 64'd16);
      tick();

      drive(32'h8B09026A, 64'd30, "add");
      check("add.rd1_const", read_data1, 64'd10);
      check("add.rd2_const", read_data2, 64'd20);
      tick();

      drive(32'hCB0A028B, 64'd50, "sub");
      check("sub.rd2_const", read_data2, 64'd30);
      tick();

      drive(32'hB4FFFF6B, 64'd7, "cbz");
      check("cbz.imm_const", sign_extended_output, 64'hFFFF_FFFF_FFFF_FFFB);
      tick();

      drive(32'h14000040, 64'd8, "b");
      check("b.imm_const", sign_extended_output, 64'h40);
      tick();

      drive(32'hF80602CB, 64'd9, "stur");
      check("stur.rd2_x11", read_data2, 64'd50);
      check("stur.imm_const", sign_extended_output, 64'h60);
      tick();

      drive(32'h8B09027F, 64'hDEAD, "write_x31");
      tick();
      drive(32'h8B1F03E0, 64'd0, "read_x31");
      check("x31_rd1_zero", read_data1, 64'd0);
      check("x31_rd2_zero", read_data2, 64'd0);
      tick();

      drive(32'h8B0A0120, 64'd0, "pre_reset");
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_x9", read_data1, 64'd0);
      check("async_reset_x10", read_data2, 64'd0);
      model_reset();
      tick();
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_all("post_reset");

      for (int i = 0; i < 300; i++) begin
         r = $urandom();
         case ($urandom_range(0, 8))
            0: op = 11'h458;
            1: op = 11'h658;
            2: op = 11'h450;
            3: op = 11'h550;
            4: op = 11'h7C2;
            5: op = 11'h7C0;
            6: op = {8'hB4, 3'($urandom_range(0, 7))};
            7: op = {6'b000101, 5'($urandom_range(0, 31))};
            default: op = 11'($urandom_range(0, 2047));
         endcase
         ins = {op, r[20:0]};
         drive(ins, {$urandom(), $urandom()}, "rand");
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
